// File: rtl/sram_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// sram_buffer_ctrl
//
// Buffer manager that keeps three circular FIFOs (input, weight, output) in a
// single-port SRAM. It sits between the AHB subordinate, the systolic array
// and the activation unit. Each BUS_W word is stored as RATIO = BUS_W/SRAM_W
// consecutive SRAM beats, with the low beat at the lower address.
//
// Ports
//   clk, rst            : clock and asynchronous active-high reset
//   write_input         : push input_data into the input FIFO
//   write_weight        : push weight_data into the weight FIFO
//   start_inference     : pop an input word to `inputs`, pulse array_start
//   load_weight         : pop a weight word to `inputs`, pulse load
//   output_read         : pop an output word to output_data, pulse output_valid
//   input_data          : host input word
//   weight_data         : host weight word
//   array_busy          : systolic array busy; array pops are refused
//   activations         : activation result word
//   activations_valid   : capture `activations` into the holding register
//   sram_read_data      : SRAM read data, valid the cycle after sram_read_en
//   output_data         : last popped output word (held)
//   output_valid        : 1-cycle pulse, output_data updated
//   data_ready          : output FIFO non-empty
//   design_busy         : FSM not IDLE
//   occupancy_err_i/w/o : 1-cycle pulse, overflow/underflow of that FIFO
//   device_busy_err     : 1-cycle pulse, a command was dropped
//   array_start, load   : 1-cycle pulses qualifying `inputs`
//   inputs              : word presented to the array (held)
//   sram_read_en, sram_write_en, sram_addr, sram_write_data : SRAM strobes
//
// Command semantics: every command input is a single-cycle request sampled
// on the rising edge. There is no ready/backpressure: a request is either
// accepted (FSM in IDLE and winning arbitration) or dropped with an error
// pulse one cycle later. A request held high for several cycles counts as
// several requests.
// -----------------------------------------------------------------------------
module sram_buffer_ctrl #(
   parameter int BUS_W     = 64,
   parameter int SRAM_W    = 32,
   parameter int ADDR_W    = 10,
   parameter int IN_DEPTH  = 64,
   parameter int W_DEPTH   = 64,
   parameter int OUT_DEPTH = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              write_input,
   input  logic              write_weight,
   input  logic              start_inference,
   input  logic              load_weight,
   input  logic              output_read,
   input  logic [BUS_W-1:0]  input_data,
   input  logic [BUS_W-1:0]  weight_data,
   input  logic              array_busy,
   input  logic [BUS_W-1:0]  activations,
   input  logic              activations_valid,
   input  logic [SRAM_W-1:0] sram_read_data,
   output logic [BUS_W-1:0]  output_data,
   output logic              output_valid,
   output logic              data_ready,
   output logic              design_busy,
   output logic              occupancy_err_i,
   output logic              occupancy_err_w,
   output logic              occupancy_err_o,
   output logic              device_busy_err,
   output logic              array_start,
   output logic              load,
   output logic [BUS_W-1:0]  inputs,
   output logic              sram_read_en,
   output logic              sram_write_en,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [SRAM_W-1:0] sram_write_data
);

   localparam int RATIO = BUS_W / SRAM_W;
   localparam int MAXD  = (IN_DEPTH > W_DEPTH) ?
                          ((IN_DEPTH > OUT_DEPTH) ? IN_DEPTH : OUT_DEPTH) :
                          ((W_DEPTH > OUT_DEPTH) ? W_DEPTH : OUT_DEPTH);
   localparam int PW    = (MAXD > 1) ? $clog2(MAXD) : 1;
   localparam int CW    = $clog2(MAXD + 1);
   localparam int BTW   = (RATIO > 1) ? $clog2(RATIO) : 1;

   localparam logic [1:0] F_IN  = 2'd0;
   localparam logic [1:0] F_W   = 2'd1;
   localparam logic [1:0] F_OUT = 2'd2;

   generate
      if (((IN_DEPTH + W_DEPTH + OUT_DEPTH) * (BUS_W / SRAM_W) > 2 ** ADDR_W) ||
          (BUS_W % SRAM_W != 0)) begin : g_param_err
         $error("sram_buffer_ctrl: FIFO regions do not fit in SRAM or BUS_W is not a multiple of SRAM_W");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WRITE   = 2'd1,
      S_READ    = 2'd2,
      S_COLLECT = 2'd3
   } state_t;

   // ---------------------------------------------------------------------------
   // Per-FIFO geometry helpers
   // ---------------------------------------------------------------------------
   function automatic int depth_of(input logic [1:0] f);
      case (f)
         F_IN:    return IN_DEPTH;
         F_W:     return W_DEPTH;
         default: return OUT_DEPTH;
      endcase
   endfunction

   function automatic logic [ADDR_W-1:0] addr_of(input logic [1:0] f, input logic [PW-1:0] p);
      int a;
      case (f)
         F_IN:    a = 0;
         F_W:     a = IN_DEPTH * RATIO;
         default: a = (IN_DEPTH + W_DEPTH) * RATIO;
      endcase
      a = a + int'(p) * RATIO;
      return ADDR_W'(a);
   endfunction

   function automatic logic [PW-1:0] next_ptr(input logic [1:0] f, input logic [PW-1:0] p);
      if (int'(p) == depth_of(f) - 1) return '0;
      return p + PW'(1);
   endfunction

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t              r_state;
   logic [1:0]          r_tgt;            // FIFO the current operation works on
   logic [BTW-1:0]      r_beat;
   logic [BUS_W-1:0]    r_word;           // remaining beats of the word being written
   logic                r_rd_d;           // sram_read_en of the previous cycle
   logic [PW-1:0]       r_wptr [0:2];
   logic [PW-1:0]       r_rptr [0:2];
   logic [CW-1:0]       r_cnt  [0:2];
   logic [BUS_W-1:0]    r_hold;
   logic                r_hold_valid;

   logic [BUS_W-1:0]    r_output_data;
   logic                r_output_valid;
   logic [BUS_W-1:0]    r_inputs;
   logic                r_array_start;
   logic                r_load;
   logic                r_err_i;
   logic                r_err_w;
   logic                r_err_o;
   logic                r_busy_err;
   logic                r_sram_re;
   logic                r_sram_we;
   logic [ADDR_W-1:0]   r_sram_addr;
   logic [SRAM_W-1:0]   r_sram_wdata;

   // ---------------------------------------------------------------------------
   // Read-beat assembly: beats arrive low first, so each new beat is shifted in
   // at the top and the first beat ends up in the least significant slot.
   // ---------------------------------------------------------------------------
   logic [BUS_W-1:0]    w_asm_next;

   generate
      if (RATIO > 1) begin : g_asm
         logic [BUS_W-SRAM_W-1:0] r_asm;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_asm <= '0;
            end else if (r_rd_d) begin
               r_asm <= w_asm_next[BUS_W-1:SRAM_W];
            end
         end
         assign w_asm_next = {sram_read_data, r_asm};
      end else begin : g_asm_single
         assign w_asm_next = sram_read_data;
      end
   endgenerate

   // ---------------------------------------------------------------------------
   // IDLE decode: arbitration and occupancy checks
   // ---------------------------------------------------------------------------
   logic [2:0]          w_full;
   logic [2:0]          w_empty;
   logic                w_any_cmd;
   logic                w_lost;
   logic                w_do_wr;
   logic                w_do_rd;
   logic [1:0]          w_tgt;
   logic [BUS_W-1:0]    w_wr_word;
   logic                w_err_i;
   logic                w_err_w;
   logic                w_err_o_cmd;
   logic                w_busy_cmd;
   logic                w_hold_clr;
   logic [ADDR_W-1:0]   w_base_addr;

   always_comb begin
      for (int f = 0; f < 3; f++) begin
         w_full[f]  = (int'(r_cnt[f]) == depth_of(2'(f)));
         w_empty[f] = (r_cnt[f] == '0);
      end
   end

   assign w_any_cmd = output_read | load_weight | start_inference | write_weight | write_input;

   // A loser exists whenever two or more requests (the pending drain counts as
   // one) are present in the same cycle.
   assign w_lost = (r_hold_valid    & w_any_cmd) |
                   (output_read     & (load_weight | start_inference | write_weight | write_input)) |
                   (load_weight     & (start_inference | write_weight | write_input)) |
                   (start_inference & (write_weight | write_input)) |
                   (write_weight    & write_input);

   always_comb begin
      w_do_wr     = 1'b0;
      w_do_rd     = 1'b0;
      w_tgt       = F_IN;
      w_wr_word   = input_data;
      w_err_i     = 1'b0;
      w_err_w     = 1'b0;
      w_err_o_cmd = 1'b0;
      w_busy_cmd  = 1'b0;
      w_hold_clr  = 1'b0;
      if (r_state == S_IDLE) begin
         w_busy_cmd = w_lost;
         if (r_hold_valid) begin
            // The holding register is always emptied, even if the word is lost.
            w_hold_clr = 1'b1;
            w_tgt      = F_OUT;
            w_wr_word  = r_hold;
            if (w_full[F_OUT]) w_err_o_cmd = 1'b1;
            else               w_do_wr     = 1'b1;
         end else if (output_read) begin
            w_tgt = F_OUT;
            if (w_empty[F_OUT]) w_err_o_cmd = 1'b1;
            else                w_do_rd     = 1'b1;
         end else if (load_weight) begin
            w_tgt = F_W;
            if (array_busy)        w_busy_cmd = 1'b1;
            else if (w_empty[F_W]) w_err_w    = 1'b1;
            else                   w_do_rd    = 1'b1;
         end else if (start_inference) begin
            w_tgt = F_IN;
            if (array_busy)         w_busy_cmd = 1'b1;
            else if (w_empty[F_IN]) w_err_i    = 1'b1;
            else                    w_do_rd    = 1'b1;
         end else if (write_weight) begin
            w_tgt     = F_W;
            w_wr_word = weight_data;
            if (w_full[F_W]) w_err_w = 1'b1;
            else             w_do_wr = 1'b1;
         end else if (write_input) begin
            w_tgt     = F_IN;
            w_wr_word = input_data;
            if (w_full[F_IN]) w_err_i = 1'b1;
            else              w_do_wr = 1'b1;
         end
      end else begin
         w_busy_cmd = w_any_cmd;
      end
   end

   assign w_base_addr = addr_of(w_tgt, w_do_wr ? r_wptr[w_tgt] : r_rptr[w_tgt]);

   // ---------------------------------------------------------------------------
   // FSM and registered outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_tgt          <= F_IN;
         r_beat         <= '0;
         r_word         <= '0;
         r_rd_d         <= 1'b0;
         for (int f = 0; f < 3; f++) begin
            r_wptr[f] <= '0;
            r_rptr[f] <= '0;
            r_cnt[f]  <= '0;
         end
         r_hold         <= '0;
         r_hold_valid   <= 1'b0;
         r_output_data  <= '0;
         r_output_valid <= 1'b0;
         r_inputs       <= '0;
         r_array_start  <= 1'b0;
         r_load         <= 1'b0;
         r_err_i        <= 1'b0;
         r_err_w        <= 1'b0;
         r_err_o        <= 1'b0;
         r_busy_err     <= 1'b0;
         r_sram_re      <= 1'b0;
         r_sram_we      <= 1'b0;
         r_sram_addr    <= '0;
         r_sram_wdata   <= '0;
      end else begin
         r_output_valid <= 1'b0;
         r_array_start  <= 1'b0;
         r_load         <= 1'b0;
         r_err_i        <= w_err_i;
         r_err_w        <= w_err_w;
         // A new activation arriving while the register is still occupied is
         // lost, even in the cycle the old one is being drained.
         r_err_o        <= w_err_o_cmd | (activations_valid & r_hold_valid);
         r_busy_err     <= w_busy_cmd;
         r_rd_d         <= r_sram_re;

         if (w_hold_clr) r_hold_valid <= 1'b0;
         if (activations_valid && !r_hold_valid) begin
            r_hold       <= activations;
            r_hold_valid <= 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               if (w_do_wr) begin
                  r_state      <= S_WRITE;
                  r_tgt        <= w_tgt;
                  r_beat       <= '0;
                  r_sram_we    <= 1'b1;
                  r_sram_addr  <= w_base_addr;
                  r_sram_wdata <= w_wr_word[SRAM_W-1:0];
                  r_word       <= w_wr_word >> SRAM_W;
               end else if (w_do_rd) begin
                  r_state      <= S_READ;
                  r_tgt        <= w_tgt;
                  r_beat       <= '0;
                  r_sram_re    <= 1'b1;
                  r_sram_addr  <= w_base_addr;
               end
            end

            S_WRITE: begin
               if (r_beat == BTW'(RATIO - 1)) begin
                  r_sram_we     <= 1'b0;
                  r_sram_addr   <= '0;
                  r_sram_wdata  <= '0;
                  r_wptr[r_tgt] <= next_ptr(r_tgt, r_wptr[r_tgt]);
                  r_cnt[r_tgt]  <= r_cnt[r_tgt] + CW'(1);
                  r_state       <= S_IDLE;
               end else begin
                  r_beat       <= r_beat + BTW'(1);
                  r_sram_addr  <= r_sram_addr + ADDR_W'(1);
                  r_sram_wdata <= r_word[SRAM_W-1:0];
                  r_word       <= r_word >> SRAM_W;
               end
            end

            S_READ: begin
               if (r_beat == BTW'(RATIO - 1)) begin
                  r_sram_re   <= 1'b0;
                  r_sram_addr <= '0;
                  r_state     <= S_COLLECT;
               end else begin
                  r_beat      <= r_beat + BTW'(1);
                  r_sram_addr <= r_sram_addr + ADDR_W'(1);
               end
            end

            S_COLLECT: begin
               // The last beat is on sram_read_data now; w_asm_next is complete.
               case (r_tgt)
                  F_OUT: begin
                     r_output_data  <= w_asm_next;
                     r_output_valid <= 1'b1;
                  end
                  F_W: begin
                     r_inputs <= w_asm_next;
                     r_load   <= 1'b1;
                  end
                  default: begin
                     r_inputs      <= w_asm_next;
                     r_array_start <= 1'b1;
                  end
               endcase
               r_rptr[r_tgt] <= next_ptr(r_tgt, r_rptr[r_tgt]);
               r_cnt[r_tgt]  <= r_cnt[r_tgt] - CW'(1);
               r_state       <= S_IDLE;
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign output_data     = r_output_data;
   assign output_valid    = r_output_valid;
   assign data_ready      = (r_cnt[F_OUT] != '0);
   assign design_busy     = (r_state != S_IDLE);
   assign occupancy_err_i = r_err_i;
   assign occupancy_err_w = r_err_w;
   assign occupancy_err_o = r_err_o;
   assign device_busy_err = r_busy_err;
   assign array_start     = r_array_start;
   assign load            = r_load;
   assign inputs          = r_inputs;
   assign sram_read_en    = r_sram_re;
   assign sram_write_en   = r_sram_we;
   assign sram_addr       = r_sram_addr;
   assign sram_write_data = r_sram_wdata;

endmodule
